// File: rtl/hs_req_tx_pkg.sv
// Shared definitions for the req/ack handshake CDC pair (transmitter and receiver side).
package hs_req_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } hs_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    // Fewer than two flops gives no real metastability protection.
    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/hs_req_tx_cdc_sync_bit.sv
// N-stage level synchroniser for one asynchronous bit, reset to 0.
module cdc_sync_bit
    import hs_req_tx_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    localparam int ST = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [ST-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[ST-2:0], d_i};
    end

    assign q_o = sync_q[ST-1];

endmodule

// File: rtl/hs_req_tx.sv
// Source end of a 4-phase req/ack handshake: accepts a word, holds it on tx_data
// with req high, and completes the cycle from the synchronised ack.
module hs_req_tx
    import hs_req_tx_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CW          = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          req,
    output logic [DW-1:0] tx_data,
    input  logic          ack_async,
    output logic          done,
    output logic          busy,
    input  logic          err_clr,
    output logic          timeout_err
);

    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

    hs_state_e     state_q, state_d;
    logic          req_q, req_d;
    logic [DW-1:0] txd_q, txd_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          ack_s;
    logic          accept;
    logic          timeout_hit;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ack_async),
        .q_o   (ack_s)
    );

    // Holding off while ack_s is high stops a stale ack from a previous
    // (possibly reset-interrupted) cycle completing a new handshake.
    assign src_ready   = (state_q == IDLE) && !ack_s;
    assign accept      = src_valid && src_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_VAL);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q & ~err_clr;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    txd_d   = src_data;
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q)                      cnt_d = '0;
        else if (state_q != IDLE && cnt_q != '1)     cnt_d = cnt_q + 1'b1;

        // Set beats clear; the FSM keeps waiting regardless.
        if (timeout_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            txd_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req         = req_q;
    assign tx_data     = txd_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

endmodule
